counter8: RTL and testbench
===========================

Name: counter8

Overview:
- Free-running 3-bit up-counter (0..7, wraps) with a built-in seven-segment decoder that shows the current count as a decimal digit.
- Used as a board-level demo/status block. Drives one seven-segment digit directly and exposes the raw count for other logic.

Parameters:
- SEG_ACTIVE_LOW, default 1. When 1, a lit segment is driven 0 (common-anode display). When 0, all oDisplay bits are inverted (common-cathode display).

Ports:
- CLK, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- oQ, output, 3: current count value, registered.
- oDisplay, output, 7: seven-segment pattern for oQ, bit order {g,f,e,d,c,b,a} (bit 6 = g, bit 0 = a).

Behaviour:
- Interface (already decided): one clock, CLK. Reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n = 0 forces oQ = 3'd0 immediately, without waiting for a clock edge.
  - oDisplay shows the "0" pattern while reset is held.
  - Reset has priority over counting.
- Counting:
  - On every CLK rising edge with rst_n = 1: oQ <= oQ + 1, modulo 8.
  - 7 -> 0 wrap-around takes one cycle; there is no terminal-count stall.
  - No enable input: the counter advances every cycle.
- Release timing: with rst_n deasserted before a rising edge, the first edge after release gives oQ = 1.
- Mid-operation reset: asserting rst_n at any count clears oQ to 0 asynchronously. Counting resumes from 0 on the first rising edge after release.
- Decoder:
  - oDisplay is a purely combinational function of oQ, with zero latency; it changes in the same cycle as oQ.
  - No glitch filtering is required.
- Segment patterns with SEG_ACTIVE_LOW = 1, as {g..a}:
  - 0 -> 7'h40, 1 -> 7'h79, 2 -> 7'h24, 3 -> 7'h30
  - 4 -> 7'h19, 5 -> 7'h12, 6 -> 7'h02, 7 -> 7'h78
- With SEG_ACTIVE_LOW = 0, each pattern is the bitwise inverse (0 -> 7'h3F, 7 -> 7'h07, etc.).
- X-safety: the decoder's default branch drives all segments off (7'h7F active-low / 7'h00 active-high). This branch is unreachable with a 3-bit count.
- Outputs are never tri-stated. No other internal state exists.

Test Plan:
- Reset then run:
  - Stimulus: CLK period 40 ns; rst_n = 0 at t = 0, released at t = 10 ns.
  - Response: oQ = 0 and oDisplay = 7'h40 during reset; oQ = 1, 2, 3 at the 1st, 2nd and 3rd rising edges.
- Full sweep and wrap:
  - Stimulus: run 9 edges from reset.
  - Response: oQ goes 1..7 then 0 then 1; oDisplay follows the table each cycle (7 -> 7'h78, 0 -> 7'h40).
- Asynchronous reset mid-count:
  - Stimulus: at oQ = 5, pull rst_n low between clock edges.
  - Response: oQ = 0 and oDisplay = 7'h40 before the next edge; they stay there while low. After release, the next edge gives oQ = 1.
- Reset held across edges:
  - Stimulus: hold rst_n = 0 for 4 rising edges.
  - Response: oQ stays 0 throughout; no increment.
- Polarity parameter:
  - Stimulus: instantiate with SEG_ACTIVE_LOW = 0 and sweep 0..7.
  - Response: oDisplay = 7'h3F, 06, 5B, 4F, 66, 6D, 7D, 07.
- Decoder consistency:
  - Stimulus: every cycle of a 20-cycle run.
  - Response: oDisplay equals the table entry for the current oQ in the same cycle, with zero latency.

Source files
------------

// File: rtl/counter8.sv
// counter8: free-running 3-bit up-counter with a seven-segment decoder of the count
module counter8 #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLK,
  input  logic       rst_n,
  output logic [2:0] oQ,
  output logic [6:0] oDisplay
);
  logic [6:0] seg;
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) oQ <= '0;
    else        oQ <= oQ + 3'd1;
  always_comb begin
    seg = 7'h7F;
    case (oQ)
      3'd0: seg = 7'h40;
      3'd1: seg = 7'h79;
      3'd2: seg = 7'h24;
      3'd3: seg = 7'h30;
      3'd4: seg = 7'h19;
      3'd5: seg = 7'h12;
      3'd6: seg = 7'h02;
      3'd7: seg = 7'h78;
      default: seg = 7'h7F;
    endcase
  end
  assign oDisplay = SEG_ACTIVE_LOW ? seg : ~seg;
endmodule

// File: tb/tb_counter8.sv
// tb_counter8: directed checks of counting, wrap, async reset and both segment polarities
module tb_counter8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] q_lo, q_hi;
  logic [6:0] disp_lo, disp_hi;
  int checks = 0;
  int failures = 0;
  localparam logic [6:0] SEG_LO [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  localparam logic [6:0] SEG_HI [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

  counter8 dut_lo (.CLK(clk), .rst_n(rst_n), .oQ(q_lo), .oDisplay(disp_lo));
  counter8 #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (.CLK(clk), .rst_n(rst_n), .oQ(q_hi), .oDisplay(disp_hi));

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int v);
    check({tag, " q"}, {5'd0, q_lo}, v[7:0]);
    check({tag, " q_hi"}, {5'd0, q_hi}, v[7:0]);
    check({tag, " disp"}, {1'b0, disp_lo}, {1'b0, SEG_LO[v]});
    check({tag, " disp_hi"}, {1'b0, disp_hi}, {1'b0, SEG_HI[v]});
  endtask

  initial begin
    #5;
    check_all("reset", 0);
    #5 rst_n = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(posedge clk) #1;
      check_all($sformatf("run%0d", i), i % 8);
    end
    #10 rst_n = 1'b0;
    #1;
    check_all("async_clear", 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk) #1;
      check_all($sformatf("hold%0d", i), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    check_all("released", 0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk) #1;
      check_all($sformatf("resume%0d", i), i);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
